// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants, request/bundle types and the hazard check for the operand fetch stage.
package operand_fetch_stage_pkg;

  localparam int unsigned NumRegs   = 16;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned SelWidth  = $clog2(NumRegs);

  typedef logic [SelWidth-1:0]  sel_t;
  typedef logic [DataWidth-1:0] data_t;

  typedef struct packed {
    sel_t       sel_ra;
    sel_t       sel_rb;
    sel_t       sel_rc;
    logic [2:0] uses;      // {rc, rb, ra}
    sel_t       dest_sel;
    logic       dest_en;
  } operand_req_t;

  typedef struct packed {
    data_t data_ra;
    data_t data_rb;
    data_t data_rc;
    sel_t  dest_sel;
    logic  dest_en;
  } operand_bundle_t;

  // busy holds the scoreboard bits looked up for {dest, rc, rb, ra}.
  function automatic logic hazard_check(input operand_req_t req, input logic [3:0] busy);
    logic haz;
    haz = (req.uses[0] && (req.sel_ra != '0) && busy[0]) ||
          (req.uses[1] && (req.sel_rb != '0) && busy[1]) ||
          (req.uses[2] && (req.sel_rc != '0) && busy[2]) ||
          (req.dest_en && (req.dest_sel != '0) && busy[3]);
    return haz;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode, register file, writeback and execute signals of the operand fetch stage.
interface operand_fetch_stage_if
  import operand_fetch_stage_pkg::*;
();

  logic       in_valid;
  logic       in_ready;
  sel_t       in_sel_ra;
  sel_t       in_sel_rb;
  sel_t       in_sel_rc;
  logic [2:0] in_uses;
  sel_t       in_dest_sel;
  logic       in_dest_en;
  logic       in_flush;

  sel_t       rf_read_sel_ra;
  sel_t       rf_read_sel_rb;
  sel_t       rf_read_sel_rc;
  data_t      rf_read_data_ra;
  data_t      rf_read_data_rb;
  data_t      rf_read_data_rc;

  logic       wb_valid;
  sel_t       wb_sel;
  data_t      wb_data;

  logic       out_valid;
  logic       out_ready;
  data_t      out_data_ra;
  data_t      out_data_rb;
  data_t      out_data_rc;
  sel_t       out_dest_sel;
  logic       out_dest_en;

  modport master (
    output in_valid, in_sel_ra, in_sel_rb, in_sel_rc, in_uses, in_dest_sel, in_dest_en, in_flush,
    output rf_read_data_ra, rf_read_data_rb, rf_read_data_rc,
    output wb_valid, wb_sel, wb_data, out_ready,
    input  in_ready, rf_read_sel_ra, rf_read_sel_rb, rf_read_sel_rc,
    input  out_valid, out_data_ra, out_data_rb, out_data_rc, out_dest_sel, out_dest_en
  );

  modport slave (
    input  in_valid, in_sel_ra, in_sel_rb, in_sel_rc, in_uses, in_dest_sel, in_dest_en, in_flush,
    input  rf_read_data_ra, rf_read_data_rb, rf_read_data_rc,
    input  wb_valid, wb_sel, wb_data, out_ready,
    output in_ready, rf_read_sel_ra, rf_read_sel_rb, rf_read_sel_rc,
    output out_valid, out_data_ra, out_data_rb, out_data_rc, out_dest_sel, out_dest_en
  );

endinterface

// File: rtl/operand_fetch_stage_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, r0 never busy.
module operand_fetch_stage_scoreboard
  import operand_fetch_stage_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic set_en_i,
  input  sel_t set_sel_i,
  input  logic clr_en_i,
  input  sel_t clr_sel_i,
  input  sel_t qry_ra_sel_i,
  input  sel_t qry_rb_sel_i,
  input  sel_t qry_rc_sel_i,
  input  sel_t qry_dest_sel_i,
  output logic busy_ra_o,
  output logic busy_rb_o,
  output logic busy_rc_o,
  output logic busy_dest_o
);

  logic [NumRegs-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_sel_i] = 1'b0;
    // A new claim must survive a retiring write to the same register.
    if (set_en_i) busy_d[set_sel_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_ra_o   = busy_q[qry_ra_sel_i];
  assign busy_rb_o   = busy_q[qry_rb_sel_i];
  assign busy_rc_o   = busy_q[qry_rc_sel_i];
  assign busy_dest_o = busy_q[qry_dest_sel_i];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: holds one decoded instruction, reads the register file with writeback bypass,
// stalls on RAW/WAW hazards and hands resolved operands to execute.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  operand_fetch_stage_if.slave bus_io
);

  logic            hold_valid_q, hold_valid_d;
  operand_req_t    hold_q, hold_d, in_req;
  logic [2:0]      byp_flag_q, byp_flag_d;
  data_t [2:0]     byp_data_q, byp_data_d;
  sel_t  [2:0]     next_sel;
  data_t [2:0]     rf_data;
  operand_bundle_t bundle;

  logic busy_ra, busy_rb, busy_rc, busy_dest;
  logic hazard, out_valid, fire_out, in_ready, accept, sb_set_en;

  always_comb begin
    in_req.sel_ra   = bus_io.in_sel_ra;
    in_req.sel_rb   = bus_io.in_sel_rb;
    in_req.sel_rc   = bus_io.in_sel_rc;
    in_req.uses     = bus_io.in_uses;
    in_req.dest_sel = bus_io.in_dest_sel;
    in_req.dest_en  = bus_io.in_dest_en;

    hazard    = hazard_check(hold_q, {busy_dest, busy_rc, busy_rb, busy_ra});
    out_valid = hold_valid_q & ~hazard;
    fire_out  = out_valid & bus_io.out_ready & ~bus_io.in_flush;
    in_ready  = ~hold_valid_q | fire_out;
    accept    = bus_io.in_valid & in_ready;
    sb_set_en = fire_out & hold_q.dest_en & (hold_q.dest_sel != '0);
  end

  always_comb begin
    hold_d       = accept ? in_req : hold_q;
    hold_valid_d = hold_valid_q;
    if (bus_io.in_flush)  hold_valid_d = 1'b0;
    else if (accept)      hold_valid_d = 1'b1;
    else if (fire_out)    hold_valid_d = 1'b0;

    next_sel = {hold_d.sel_rc, hold_d.sel_rb, hold_d.sel_ra};
    rf_data  = {bus_io.rf_read_data_rc, bus_io.rf_read_data_rb, bus_io.rf_read_data_ra};
    // The register file returns pre-write data, so capture a same-edge writeback here.
    for (int i = 0; i < 3; i++) begin
      byp_flag_d[i] = bus_io.wb_valid && (bus_io.wb_sel == next_sel[i]) && (next_sel[i] != '0);
      byp_data_d[i] = bus_io.wb_data;
    end

    bundle.data_ra  = byp_flag_q[0] ? byp_data_q[0] : rf_data[0];
    bundle.data_rb  = byp_flag_q[1] ? byp_data_q[1] : rf_data[1];
    bundle.data_rc  = byp_flag_q[2] ? byp_data_q[2] : rf_data[2];
    bundle.dest_sel = hold_q.dest_sel;
    bundle.dest_en  = hold_q.dest_en;
  end

  always_comb begin
    bus_io.in_ready       = in_ready;
    bus_io.out_valid      = out_valid;
    bus_io.rf_read_sel_ra = next_sel[0];
    bus_io.rf_read_sel_rb = next_sel[1];
    bus_io.rf_read_sel_rc = next_sel[2];
    bus_io.out_data_ra    = bundle.data_ra;
    bus_io.out_data_rb    = bundle.data_rb;
    bus_io.out_data_rc    = bundle.data_rc;
    bus_io.out_dest_sel   = bundle.dest_sel;
    bus_io.out_dest_en    = bundle.dest_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      byp_flag_q   <= '0;
      byp_data_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      byp_flag_q   <= byp_flag_d;
      byp_data_q   <= byp_data_d;
    end
  end

  operand_fetch_stage_scoreboard u_scoreboard (
    .clk_i          (clk),
    .rst_i          (rst),
    .set_en_i       (sb_set_en),
    .set_sel_i      (hold_q.dest_sel),
    .clr_en_i       (bus_io.wb_valid),
    .clr_sel_i      (bus_io.wb_sel),
    .qry_ra_sel_i   (hold_q.sel_ra),
    .qry_rb_sel_i   (hold_q.sel_rb),
    .qry_rc_sel_i   (hold_q.sel_rc),
    .qry_dest_sel_i (hold_q.dest_sel),
    .busy_ra_o      (busy_ra),
    .busy_rb_o      (busy_rb),
    .busy_rc_o      (busy_rc),
    .busy_dest_o    (busy_dest)
  );

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: cycle table, directed corner sequences, random vs. reference model.
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rf_clr;
  always #5 clk = ~clk;

  operand_fetch_stage_if bus ();

  operand_fetch_stage dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Register file: synchronous read, no write forwarding, r0 reads zero.
  data_t regs [NumRegs];
  always @(posedge clk) begin
    bus.rf_read_data_ra <= (bus.rf_read_sel_ra == '0) ? '0 : regs[bus.rf_read_sel_ra];
    bus.rf_read_data_rb <= (bus.rf_read_sel_rb == '0) ? '0 : regs[bus.rf_read_sel_rb];
    bus.rf_read_data_rc <= (bus.rf_read_sel_rc == '0) ? '0 : regs[bus.rf_read_sel_rc];
    if (rf_clr) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
    end else if (bus.wb_valid && bus.wb_sel != '0) begin
      regs[bus.wb_sel] <= bus.wb_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       in_valid;
    sel_t       ra;
    sel_t       rb;
    logic [2:0] uses;
    sel_t       dest;
    logic       den;
    logic       wbv;
    sel_t       wbs;
    data_t      wbd;
    logic       ordy;
    logic       x_in_ready;
    logic       x_out_valid;
    logic [1:0] chk;
    data_t      x_ra;
    data_t      x_rb;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic iv, input sel_t ra, input sel_t rb,
                              input logic [2:0] uses, input sel_t dest, input logic den,
                              input logic wbv, input sel_t wbs, input data_t wbd,
                              input logic x_ir, input logic x_ov, input logic [1:0] chk,
                              input data_t x_ra, input data_t x_rb);
    vec_t v;
    v.in_valid = iv;  v.ra = ra;  v.rb = rb;  v.uses = uses;  v.dest = dest;  v.den = den;
    v.wbv = wbv;  v.wbs = wbs;  v.wbd = wbd;  v.ordy = 1'b1;
    v.x_in_ready = x_ir;  v.x_out_valid = x_ov;  v.chk = chk;  v.x_ra = x_ra;  v.x_rb = x_rb;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.in_valid    = 1'b0;
    bus.in_sel_ra   = '0;
    bus.in_sel_rb   = '0;
    bus.in_sel_rc   = '0;
    bus.in_uses     = '0;
    bus.in_dest_sel = '0;
    bus.in_dest_en  = 1'b0;
    bus.in_flush    = 1'b0;
    bus.wb_valid    = 1'b0;
    bus.wb_sel      = '0;
    bus.wb_data     = '0;
    bus.out_ready   = 1'b1;
  endtask

  task automatic issue(input sel_t ra, input sel_t rb, input sel_t rc, input logic [2:0] uses,
                       input sel_t dest, input logic den);
    bus.in_valid    = 1'b1;
    bus.in_sel_ra   = ra;
    bus.in_sel_rb   = rb;
    bus.in_sel_rc   = rc;
    bus.in_uses     = uses;
    bus.in_dest_sel = dest;
    bus.in_dest_en  = den;
  endtask

  task automatic wb(input sel_t s, input data_t d);
    bus.wb_valid = 1'b1;
    bus.wb_sel   = s;
    bus.wb_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  // Reference model state for the random phase.
  sel_t       pend[$];
  logic       m_valid;
  sel_t       m_ra, m_rb, m_rc, m_dest;
  logic [2:0] m_uses;
  logic       m_den;
  int         wb_idx;
  logic       haz, x_ov, fire, x_ir, acc;

  function automatic logic is_pend(input sel_t s);
    if (s == '0) return 1'b0;
    foreach (pend[k]) if (pend[k] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic data_t arch_val(input sel_t s);
    return (s == '0) ? '0 : regs[s];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    rst    = 1'b1;
    rf_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    rf_clr = 1'b0;
    @(negedge clk);
    chk1("reset out_valid", bus.out_valid, 1'b0);
    chk1("reset in_ready", bus.in_ready, 1'b1);
    chk32("reset rf_read_sel", 32'({bus.rf_read_sel_rc, bus.rf_read_sel_rb, bus.rf_read_sel_ra}),
          32'h0);

    // Basic read, same-edge bypass, RAW stall released by writeback.
    vecs[0]  = mk(0, 0, 0, 3'b000, 0, 0, 1, 5, 32'h1234,     1, 0, 2'b00, 0, 0);
    vecs[1]  = mk(0, 0, 0, 3'b000, 0, 0, 1, 3, 32'h11111111, 1, 0, 2'b00, 0, 0);
    vecs[2]  = mk(1, 5, 0, 3'b011, 0, 0, 0, 0, 0,            1, 0, 2'b00, 0, 0);
    vecs[3]  = mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0,            1, 1, 2'b11, 32'h1234, 0);
    vecs[4]  = mk(1, 3, 0, 3'b001, 0, 0, 1, 3, 32'hDEADBEEF, 1, 0, 2'b00, 0, 0);
    vecs[5]  = mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0,            1, 1, 2'b01, 32'hDEADBEEF, 0);
    vecs[6]  = mk(1, 1, 0, 3'b000, 7, 1, 0, 0, 0,            1, 0, 2'b00, 0, 0);
    vecs[7]  = mk(1, 7, 0, 3'b001, 0, 0, 0, 0, 0,            1, 1, 2'b00, 0, 0);
    vecs[8]  = mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0,            0, 0, 2'b00, 0, 0);
    vecs[9]  = mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0,            0, 0, 2'b00, 0, 0);
    vecs[10] = mk(0, 0, 0, 3'b000, 0, 0, 1, 7, 32'h55,       0, 0, 2'b00, 0, 0);
    vecs[11] = mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0,            1, 1, 2'b01, 32'h55, 0);
    vecs[12] = mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0,            1, 0, 2'b00, 0, 0);

    foreach (vecs[i]) begin
      tick();
      if (vecs[i].in_valid) issue(vecs[i].ra, vecs[i].rb, '0, vecs[i].uses, vecs[i].dest,
                                  vecs[i].den);
      if (vecs[i].wbv) wb(vecs[i].wbs, vecs[i].wbd);
      bus.out_ready = vecs[i].ordy;
      @(negedge clk);
      chk1($sformatf("vec%0d in_ready", i), bus.in_ready, vecs[i].x_in_ready);
      chk1($sformatf("vec%0d out_valid", i), bus.out_valid, vecs[i].x_out_valid);
      if (vecs[i].chk[0]) chk32($sformatf("vec%0d data_ra", i), bus.out_data_ra, vecs[i].x_ra);
      if (vecs[i].chk[1]) chk32($sformatf("vec%0d data_rb", i), bus.out_data_rb, vecs[i].x_rb);
    end

    // Back-pressure: held operands stay put, nothing new enters.
    tick(); issue(5, 3, 0, 3'b011, 0, 0); bus.out_ready = 1'b0;
    @(negedge clk);
    chk1("bp accept in_ready", bus.in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(); issue(7, 0, 0, 3'b001, 0, 0); bus.out_ready = 1'b0;
      @(negedge clk);
      chk1("bp out_valid", bus.out_valid, 1'b1);
      chk1("bp in_ready", bus.in_ready, 1'b0);
      chk32("bp data_ra", bus.out_data_ra, 32'h1234);
      chk32("bp data_rb", bus.out_data_rb, 32'hDEADBEEF);
    end
    tick(); issue(7, 0, 0, 3'b001, 0, 0);
    @(negedge clk);
    chk1("bp release in_ready", bus.in_ready, 1'b1);
    chk32("bp release data_ra", bus.out_data_ra, 32'h1234);
    tick();
    @(negedge clk);
    chk1("bp next out_valid", bus.out_valid, 1'b1);
    chk32("bp next data_ra", bus.out_data_ra, 32'h55);
    tick();
    @(negedge clk);
    chk1("bp drained out_valid", bus.out_valid, 1'b0);

    // Set/clear collision on r4: the new claim wins.
    tick(); issue(0, 0, 0, 3'b000, 4, 1);
    @(negedge clk);
    tick(); issue(4, 0, 0, 3'b001, 0, 0); wb(4, 32'hAAAA);
    @(negedge clk);
    chk1("coll fire out_valid", bus.out_valid, 1'b1);
    chk32("coll dest_sel", 32'(bus.out_dest_sel), 32'd4);
    chk1("coll dest_en", bus.out_dest_en, 1'b1);
    tick();
    @(negedge clk);
    chk1("coll stall1 out_valid", bus.out_valid, 1'b0);
    chk1("coll stall1 in_ready", bus.in_ready, 1'b0);
    tick();
    @(negedge clk);
    chk1("coll stall2 out_valid", bus.out_valid, 1'b0);
    tick(); wb(4, 32'hBBBB);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk1("coll release out_valid", bus.out_valid, 1'b1);
    chk32("coll release data_ra", bus.out_data_ra, 32'hBBBB);

    // Reset during a RAW stall.
    tick(); issue(0, 0, 0, 3'b000, 7, 1);
    @(negedge clk);
    tick(); issue(7, 0, 0, 3'b001, 0, 0);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk1("rst pre stall out_valid", bus.out_valid, 1'b0);
    tick(); rst = 1'b1;
    @(negedge clk);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk1("rst post out_valid", bus.out_valid, 1'b0);
    chk1("rst post in_ready", bus.in_ready, 1'b1);
    tick(); issue(7, 0, 0, 3'b001, 0, 0);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk1("rst reissue out_valid", bus.out_valid, 1'b1);
    chk32("rst reissue data_ra", bus.out_data_ra, 32'h55);

    // Flush during a stall: instruction dropped, claim on r9 kept.
    tick(); issue(0, 0, 0, 3'b000, 9, 1);
    @(negedge clk);
    tick(); issue(9, 0, 0, 3'b001, 0, 0);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk1("flush pre out_valid", bus.out_valid, 1'b0);
    tick(); bus.in_flush = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk1("flush dropped out_valid", bus.out_valid, 1'b0);
    chk1("flush dropped in_ready", bus.in_ready, 1'b1);
    tick(); issue(9, 0, 0, 3'b001, 0, 0);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk1("flush busy kept out_valid", bus.out_valid, 1'b0);
    tick(); wb(9, 32'h99);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk1("flush wb release out_valid", bus.out_valid, 1'b1);
    chk32("flush wb release data_ra", bus.out_data_ra, 32'h99);

    // Flush blocks the transfer, so r10 is never claimed.
    tick(); issue(0, 0, 0, 3'b000, 10, 1);
    @(negedge clk);
    tick(); bus.in_flush = 1'b1;
    @(negedge clk);
    chk1("flush fire out_valid", bus.out_valid, 1'b1);
    chk1("flush fire in_ready", bus.in_ready, 1'b0);
    tick(); issue(10, 0, 0, 3'b001, 0, 0);
    @(negedge clk);
    chk1("flush fire next in_ready", bus.in_ready, 1'b1);
    tick();
    @(negedge clk);
    chk1("flush no claim out_valid", bus.out_valid, 1'b1);

    // Flush also drops an instruction accepted in the same cycle.
    tick(); issue(5, 0, 0, 3'b001, 0, 0); bus.in_flush = 1'b1;
    @(negedge clk);
    chk1("flush accept in_ready", bus.in_ready, 1'b1);
    tick();
    @(negedge clk);
    chk1("flush accept dropped out_valid", bus.out_valid, 1'b0);

    // Random phase from a clean scoreboard.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    m_valid = 1'b0;
    m_ra = '0; m_rb = '0; m_rc = '0; m_dest = '0; m_uses = '0; m_den = 1'b0;
    pend.delete();
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 3) != 0)
        issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_flush  = ($urandom_range(0, 31) == 0);
      wb_idx = -1;
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb_idx = int'($urandom_range(0, pend.size() - 1));
        wb(pend[wb_idx], $urandom);
      end
      @(negedge clk);

      haz  = m_valid && ((m_uses[0] && is_pend(m_ra)) || (m_uses[1] && is_pend(m_rb)) ||
                         (m_uses[2] && is_pend(m_rc)) || (m_den && is_pend(m_dest)));
      x_ov = m_valid && !haz;
      fire = x_ov && bus.out_ready && !bus.in_flush;
      x_ir = !m_valid || fire;
      chk1("rnd out_valid", bus.out_valid, x_ov);
      chk1("rnd in_ready", bus.in_ready, x_ir);
      if (x_ov) begin
        if (m_uses[0]) chk32("rnd data_ra", bus.out_data_ra, arch_val(m_ra));
        if (m_uses[1]) chk32("rnd data_rb", bus.out_data_rb, arch_val(m_rb));
        if (m_uses[2]) chk32("rnd data_rc", bus.out_data_rc, arch_val(m_rc));
        chk32("rnd dest_sel", 32'(bus.out_dest_sel), 32'(m_dest));
        chk1("rnd dest_en", bus.out_dest_en, m_den);
      end

      if (wb_idx >= 0) pend.delete(wb_idx);
      if (fire && m_den && m_dest != '0) pend.push_back(m_dest);
      acc = bus.in_valid && x_ir;
      if (bus.in_flush) begin
        m_valid = 1'b0;
      end else if (acc) begin
        m_valid = 1'b1;
      end else if (fire) begin
        m_valid = 1'b0;
      end
      if (acc) begin
        m_ra = bus.in_sel_ra; m_rb = bus.in_sel_rb; m_rc = bus.in_sel_rc;
        m_uses = bus.in_uses; m_dest = bus.in_dest_sel; m_den = bus.in_dest_en;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
